// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one GROUP-bit lookahead block per stage.
// Ports: clk, rst (async, active high); in_valid/in_ready with A, B, Cin, sub;
//        out_valid/out_ready with sum, Cout (1 = no borrow when subtracting),
//        overflow (signed) and zero.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             Cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NSTAGE = WIDTH / GROUP;

    // Every carry is a flat sum of products of g/p terms and the group
    // carry-in, so no carry waits on the carry below it.
    function automatic logic [GROUP:0] cla_grp(
        input logic [GROUP-1:0] a,
        input logic [GROUP-1:0] b,
        input logic             ci
    );
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             t;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            t = ci;
            for (int j = 0; j <= i; j++) begin
                t = t & p[j];
            end
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    t = t & p[m];
                end
                c[i+1] = c[i+1] | t;
            end
        end
        return {c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    for (genvar k = 0; k < NSTAGE; k++) begin : stg
        // IW: operand bits still unprocessed on entry; SW: sum bits known on exit
        localparam int IW = WIDTH - k * GROUP;
        localparam int SW = (k + 1) * GROUP;

        logic           v_in;
        logic           c_in;
        logic [IW-1:0]  a_in;
        logic [IW-1:0]  b_in;
        logic [SW-1:0]  sum_nx;
        logic [GROUP:0] grp;
        logic           nxt_ld;
        logic           ld;
        logic           en;
        logic           vld_q;
        logic           vld_d;
        logic           cy_q;
        logic           cy_d;
        logic [SW-1:0]  sum_q;
        logic [SW-1:0]  sum_d;

        assign grp = cla_grp(a_in[GROUP-1:0], b_in[GROUP-1:0], c_in);
        // Slot is free when empty or when its contents move on this cycle
        assign ld  = ~vld_q | nxt_ld;
        assign en  = ld & v_in;

        if (k == 0) begin : g_src
            assign v_in   = in_valid;
            assign c_in   = sub | Cin;
            assign a_in   = A;
            assign b_in   = sub ? ~B : B;
            assign sum_nx = grp[GROUP-1:0];
        end else begin : g_src
            assign v_in   = stg[k-1].vld_q;
            assign c_in   = stg[k-1].cy_q;
            assign a_in   = stg[k-1].g_fwd.a_q;
            assign b_in   = stg[k-1].g_fwd.b_q;
            assign sum_nx = {grp[GROUP-1:0], stg[k-1].sum_q};
        end

        always_comb begin
            vld_d = vld_q;
            cy_d  = cy_q;
            sum_d = sum_q;
            if (ld) begin
                vld_d = v_in;
            end
            if (en) begin
                cy_d  = grp[GROUP];
                sum_d = sum_nx;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
            end else begin
                vld_q <= vld_d;
                cy_q  <= cy_d;
                sum_q <= sum_d;
            end
        end

        if (k < NSTAGE - 1) begin : g_fwd
            localparam int RW = IW - GROUP;

            logic [RW-1:0] a_q;
            logic [RW-1:0] a_d;
            logic [RW-1:0] b_q;
            logic [RW-1:0] b_d;

            assign nxt_ld = stg[k+1].ld;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (en) begin
                    a_d = a_in[IW-1:GROUP];
                    b_d = b_in[IW-1:GROUP];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end else begin : g_out
            logic cmsb;
            logic ovf_q;
            logic ovf_d;
            logic zero_q;
            logic zero_d;

            assign nxt_ld = out_ready;
            // Carry into the MSB recovered from its sum bit and propagate term
            assign cmsb   = grp[GROUP-1] ^ a_in[GROUP-1] ^ b_in[GROUP-1];

            always_comb begin
                ovf_d  = ovf_q;
                zero_d = zero_q;
                if (en) begin
                    ovf_d  = cmsb ^ grp[GROUP];
                    zero_d = ~|sum_nx;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else begin
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                end
            end
        end
    end

    assign in_ready  = stg[0].ld;
    assign out_valid = stg[NSTAGE-1].vld_q;
    assign sum       = stg[NSTAGE-1].sum_q;
    assign Cout      = stg[NSTAGE-1].cy_q;
    assign overflow  = stg[NSTAGE-1].g_out.ovf_q;
    assign zero      = stg[NSTAGE-1].g_out.zero_q;

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor, generalised from the team's 4-bit CLA. The WIDTH-bit operands are split into GROUP-bit lookahead blocks, with one block resolved per pipeline stage. A valid/ready stream interface on both sides supports full throughput (one operation per clock) and backpressure. Add/subtract mode is selected per operation, and carry, signed-overflow and zero flags are produced. It serves as the arithmetic core for datapaths that need adds wider than 4 bits at speed.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of GROUP, minimum 4.
GROUP, 4, bits per lookahead block; must be 2 to 8. Number of stages NSTAGE = WIDTH/GROUP.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  an operation is presented on A, B, Cin, sub
in_ready  output  1  the block accepts the operation this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
Cin  input  1  carry in; ignored when sub=1
sub  input  1  0: A+B+Cin; 1: A-B (computed as A + ~B + 1)
out_valid  output  1  the result on sum and the flags is valid
out_ready  input  1  downstream accepts the result
sum  output  WIDTH  result
Cout  output  1  carry out of MSB; in subtract mode, 1 = no borrow
overflow  output  1  signed overflow = carry into MSB XOR Cout
zero  output  1  sum == 0

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0; all data and flag registers 0; out_valid=0; sum=0; Cout=0; overflow=0; zero=0. in_ready=1 as soon as reset deasserts.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Operand preprocessing at stage 0: Bx = sub ? ~B : B; c0 = sub ? 1 : Cin.
- Stage k (0..NSTAGE-1):
  - Computes bits [k*GROUP +: GROUP] of sum.
  - Uses generate/propagate lookahead (Gi = Ai&Bxi, Pi = Ai^Bxi, full lookahead carries within the group) from the carry registered by stage k-1 (c0 for k=0).
  - Registers: the partial sum bits computed so far, the group carry-out, the remaining unprocessed operand slices (skewed forward), and the carry into the MSB when the MSB group is processed.
  - No ripple across groups within one cycle.
- Output is the last stage register. sum, Cout, overflow and zero are all registered and aligned with out_valid. zero is computed from the final sum in the last stage.
- Latency: NSTAGE cycles from input transfer to out_valid with out_ready held high (4 for defaults). Throughput is 1 operation per clock.
- Flow control, per stage k:
  - Loads when its slot is empty or its contents advance this cycle. Stage k advances when stage k+1 loads; the last stage advances on output transfer.
  - in_ready = stage 0 can load; it is combinational from out_ready through the stage chain.
  - Bubbles collapse: an empty stage is filled even while downstream is stalled.
- Capacity: NSTAGE operations in flight. When all stages are full and out_ready=0, in_ready=0.
- While stalled, held stages keep their data and out_valid stays asserted with stable outputs until transfer.
- Simultaneous input and output transfer in the same cycle is legal; no bubble is inserted.
- Ordering: results leave strictly in input order.
- Reset mid-stream: all in-flight operations are discarded immediately and out_valid drops asynchronously.
- Arithmetic is modulo 2^WIDTH. overflow is meaningful for two's-complement interpretation, in both modes.

Test Plan:
1. Add, out_ready=1: A=0x00FF, B=0x0001, Cin=0, sub=0 -> 4 cycles later sum=0x0100, Cout=0, overflow=0, zero=0.
2. Wrap: A=0xFFFF, B=0x0001, Cin=0 -> sum=0x0000, Cout=1, zero=1, overflow=0. Then A=0x7FFF, B=0x0000, Cin=1 -> sum=0x8000, overflow=1, Cout=0.
3. Subtract: A=0x8000, B=0x0001, sub=1, Cin=1 (ignored) -> sum=0x7FFF, Cout=1, overflow=1. Then A=0x0003, B=0x0005, sub=1 -> sum=0xFFFE, Cout=0, overflow=0.
4. Backpressure: stream 8 random ops back-to-back with out_ready=0 for cycles 5-7 -> in_ready low once 4 ops are in flight; out_valid and outputs stable while stalled; all 8 results match the reference model, in order, with no drop or duplicate.
5. Bubbles and concurrency: in_valid toggling every other cycle with out_ready random -> each result appears exactly once. Where input and output transfer coincide, full throughput is sustained.
6. Reset mid-stream: assert rst with 3 ops in flight and out_valid=1 -> out_valid=0 and all outputs 0 immediately. After release, no stale results appear, and a new 0x1234+0x4321 yields 0x5555 after 4 cycles.
